// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port synchronous memory.
// Data wins by default; a starvation counter forces fetch through after STARVE_LIMIT refusals.
module mem_arbiter #(
  parameter int IDX_W        = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a request transfers in the cycle where valid && ready; the requester
  // holds valid and payload stable until then. ready is combinational, at most one per cycle.
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [31:0]      i_addr,
  output logic             i_rsp_valid,
  output logic [31:0]      i_rdata,
  output logic             i_rsp_err,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [31:0]      d_addr,
  input  logic             d_we,
  input  logic [31:0]      d_wdata,
  input  logic [3:0]       d_wstrb,
  output logic             d_rsp_valid,
  output logic [31:0]      d_rdata,
  output logic             d_rsp_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       force_i;
  logic       grant_i;
  logic       grant_d;
  logic       i_mis;
  logic       d_mis;

  // Response tag for the request accepted in the previous cycle.
  logic       tag_valid;
  logic       tag_owner_d;
  logic       tag_load;
  logic       tag_err;

  assign force_i = (starve_cnt >= LIMIT);
  assign i_mis   = (i_addr[1:0] != 2'b00);
  // Sub-word stores are trusted to keep their strobes inside the word.
  assign d_mis   = (!d_we || d_wstrb == 4'hF) && (d_addr[1:0] != 2'b00);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n) begin
      if (d_valid && !(i_valid && force_i))
        grant_d = 1'b1;
      else if (i_valid)
        grant_i = 1'b1;
    end
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n)
      starve_cnt <= 4'd0;
    else if (!i_valid || grant_i)
      starve_cnt <= 4'd0;
    else if (starve_cnt != 4'hF)
      starve_cnt <= starve_cnt + 4'd1;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    if (grant_i && !i_mis) begin
      mem_en   = 1'b1;
      mem_addr = i_addr[IDX_W+1:2];
    end
    if (grant_d) begin
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
      if (!d_mis) begin
        mem_en   = 1'b1;
        mem_we   = d_we;
        mem_addr = d_addr[IDX_W+1:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_valid   <= 1'b0;
      tag_owner_d <= 1'b0;
      tag_load    <= 1'b0;
      tag_err     <= 1'b0;
    end else begin
      tag_valid   <= grant_i || grant_d;
      tag_owner_d <= grant_d;
      tag_load    <= grant_i || (grant_d && !d_we);
      tag_err     <= grant_i ? i_mis : (grant_d && d_mis);
    end
  end

  // Gating with rst_n drops a response already in flight when reset lands.
  logic        rsp_live;
  logic [31:0] rsp_data;

  assign rsp_live    = tag_valid && rst_n;
  assign rsp_data    = (tag_load && !tag_err) ? mem_rdata : 32'd0;

  assign i_rsp_valid = rsp_live && !tag_owner_d;
  assign i_rsp_err   = i_rsp_valid && tag_err;
  assign i_rdata     = i_rsp_valid ? rsp_data : 32'd0;

  assign d_rsp_valid = rsp_live && tag_owner_d;
  assign d_rsp_err   = d_rsp_valid && tag_err;
  assign d_rdata     = d_rsp_valid ? rsp_data : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour plus
// hand-written starvation and reset-mid-flight sequences, against a behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rdata;
  logic        i_rsp_err;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_rsp_valid;
  logic [31:0] d_rdata;
  logic        d_rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.IDX_W(10), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata), .i_rsp_err(i_rsp_err),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_we(d_we),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_rsp_err(d_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural memory, preloaded once on the first clock.
  logic [31:0] mem [0:1023];
  logic        preloaded = 1'b0;

  always @(posedge clk) begin
    if (!preloaded) begin
      mem[4]    <= 32'h0050_0093;
      mem[8]    <= 32'hDEAD_BEEF;
      mem[16]   <= 32'h1122_3344;
      preloaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    logic iv; logic [31:0] ia;
    logic dv; logic [31:0] da; logic dwe; logic [31:0] dwd; logic [3:0] dws;
    logic e_ir; logic e_dr; logic e_en; logic e_we; logic [9:0] e_addr;
    logic [31:0] e_wd; logic [3:0] e_ws;
    logic e_irv; logic [31:0] e_ird; logic e_ierr;
    logic e_drv; logic [31:0] e_drd; logic e_derr;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // driver
  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
                       input logic dwe, input logic [31:0] dwd, input logic [3:0] dws);
    i_valid = iv; i_addr = ia;
    d_valid = dv; d_addr = da; d_we = dwe; d_wdata = dwd; d_wstrb = dws;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0);
  endtask

  initial begin
    // Response columns describe what is visible during the row's cycle (the previous row's grant).
    //           iv  ia     dv  da     dwe dwd           dws    ir dr en we addr wd            ws     irv ird           ierr drv drd           derr
    vecs[0]  = '{0, 32'h0,  0, 32'h0,  0, 32'h0,         4'h0,  0, 0, 0, 0, 10'd0,  32'h0,     4'h0,  0, 32'h0,         0,   0, 32'h0,         0};
    vecs[1]  = '{1, 32'h10, 0, 32'h0,  0, 32'h0,         4'h0,  1, 0, 1, 0, 10'd4,  32'h0,     4'h0,  0, 32'h0,         0,   0, 32'h0,         0};
    vecs[2]  = '{0, 32'h0,  0, 32'h0,  0, 32'h0,         4'h0,  0, 0, 0, 0, 10'd0,  32'h0,     4'h0,  1, 32'h0050_0093, 0,   0, 32'h0,         0};
    vecs[3]  = '{1, 32'h10, 1, 32'h20, 0, 32'h0,         4'h0,  0, 1, 1, 0, 10'd8,  32'h0,     4'h0,  0, 32'h0,         0,   0, 32'h0,         0};
    vecs[4]  = '{1, 32'h10, 0, 32'h0,  0, 32'h0,         4'h0,  1, 0, 1, 0, 10'd4,  32'h0,     4'h0,  0, 32'h0,         0,   1, 32'hDEAD_BEEF, 0};
    vecs[5]  = '{0, 32'h0,  0, 32'h0,  0, 32'h0,         4'h0,  0, 0, 0, 0, 10'd0,  32'h0,     4'h0,  1, 32'h0050_0093, 0,   0, 32'h0,         0};
    vecs[6]  = '{0, 32'h0,  1, 32'h40, 1, 32'h0000_00AB, 4'h1,  0, 1, 1, 1, 10'd16, 32'hAB,    4'h1,  0, 32'h0,         0,   0, 32'h0,         0};
    vecs[7]  = '{0, 32'h0,  1, 32'h40, 0, 32'h0,         4'h0,  0, 1, 1, 0, 10'd16, 32'h0,     4'h0,  0, 32'h0,         0,   1, 32'h0,         0};
    vecs[8]  = '{1, 32'h6,  0, 32'h0,  0, 32'h0,         4'h0,  1, 0, 0, 0, 10'd0,  32'h0,     4'h0,  0, 32'h0,         0,   1, 32'h1122_33AB, 0};
    vecs[9]  = '{0, 32'h0,  1, 32'h22, 0, 32'h0,         4'h0,  0, 1, 0, 0, 10'd0,  32'h0,     4'h0,  1, 32'h0,         1,   0, 32'h0,         0};
    vecs[10] = '{0, 32'h0,  1, 32'h41, 1, 32'h0000_CD00, 4'h2,  0, 1, 1, 1, 10'd16, 32'hCD00,  4'h2,  0, 32'h0,         0,   1, 32'h0,         1};
    vecs[11] = '{0, 32'h0,  1, 32'h42, 1, 32'h0,         4'hF,  0, 1, 0, 0, 10'd0,  32'h0,     4'hF,  0, 32'h0,         0,   1, 32'h0,         0};
    vecs[12] = '{0, 32'h0,  1, 32'h40, 0, 32'h0,         4'h0,  0, 1, 1, 0, 10'd16, 32'h0,     4'h0,  0, 32'h0,         0,   1, 32'h0,         1};
    vecs[13] = '{0, 32'h0,  0, 32'h0,  0, 32'h0,         4'h0,  0, 0, 0, 0, 10'd0,  32'h0,     4'h0,  0, 32'h0,         0,   1, 32'h1122_CDAB, 0};

    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    chk("reset d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("reset i_rsp_err",   32'(i_rsp_err),   32'd0);
    chk("reset d_rsp_err",   32'(d_rsp_err),   32'd0);

    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      drive(vecs[k].iv, vecs[k].ia, vecs[k].dv, vecs[k].da, vecs[k].dwe, vecs[k].dwd, vecs[k].dws);
      #1;
      chk($sformatf("v%0d i_ready", k),     32'(i_ready),     32'(vecs[k].e_ir));
      chk($sformatf("v%0d d_ready", k),     32'(d_ready),     32'(vecs[k].e_dr));
      chk($sformatf("v%0d mem_en", k),      32'(mem_en),      32'(vecs[k].e_en));
      chk($sformatf("v%0d mem_we", k),      32'(mem_we),      32'(vecs[k].e_we));
      chk($sformatf("v%0d mem_addr", k),    32'(mem_addr),    32'(vecs[k].e_addr));
      chk($sformatf("v%0d mem_wdata", k),   mem_wdata,        vecs[k].e_wd);
      chk($sformatf("v%0d mem_wstrb", k),   32'(mem_wstrb),   32'(vecs[k].e_ws));
      chk($sformatf("v%0d i_rsp_valid", k), 32'(i_rsp_valid), 32'(vecs[k].e_irv));
      chk($sformatf("v%0d i_rdata", k),     i_rdata,          vecs[k].e_ird);
      chk($sformatf("v%0d i_rsp_err", k),   32'(i_rsp_err),   32'(vecs[k].e_ierr));
      chk($sformatf("v%0d d_rsp_valid", k), 32'(d_rsp_valid), 32'(vecs[k].e_drv));
      chk($sformatf("v%0d d_rdata", k),     d_rdata,          vecs[k].e_drd);
      chk($sformatf("v%0d d_rsp_err", k),   32'(d_rsp_err),   32'(vecs[k].e_derr));
    end

    // Starvation: both held for 10 cycles; fetch gets through on cycles 5 and 10.
    begin
      logic prev_d;
      logic exp_i;
      prev_d = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        drive(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 32'd0, 4'd0);
        #1;
        exp_i = (c == 5) || (c == 10);
        chk($sformatf("starve c%0d i_ready", c), 32'(i_ready), 32'(exp_i));
        chk($sformatf("starve c%0d d_ready", c), 32'(d_ready), 32'(!exp_i));
        if (c > 1) begin
          chk($sformatf("starve c%0d d_rsp_valid", c), 32'(d_rsp_valid), 32'(prev_d));
          chk($sformatf("starve c%0d i_rsp_valid", c), 32'(i_rsp_valid), 32'(!prev_d));
        end
        prev_d = !exp_i;
      end
      @(negedge clk);
      idle();
      #1;
      chk("starve tail i_rsp_valid", 32'(i_rsp_valid), 32'd1);
      chk("starve tail i_rdata",     i_rdata,          32'h0050_0093);
    end

    // Reset lands one cycle after a load grant; a store held during reset must not write.
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b1, 32'h20, 1'b0, 32'd0, 4'd0);
    #1;
    chk("rst grant d_ready", 32'(d_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 32'hFFFF_FFFF, 4'hF);
    #1;
    chk("rst d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst d_ready",     32'(d_ready),     32'd0);
    chk("rst i_ready",     32'(i_ready),     32'd0);
    chk("rst mem_en",      32'(mem_en),      32'd0);
    chk("rst mem_we",      32'(mem_we),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("post-rst%0d d_rsp_valid", c), 32'(d_rsp_valid), 32'd0);
      chk($sformatf("post-rst%0d i_rsp_valid", c), 32'(i_rsp_valid), 32'd0);
      chk($sformatf("post-rst%0d mem_en", c),      32'(mem_en),      32'd0);
      @(negedge clk);
    end
    drive(1'b0, 32'd0, 1'b1, 32'h40, 1'b0, 32'd0, 4'd0);
    #1;
    chk("post-rst load d_ready", 32'(d_ready), 32'd1);
    chk("post-rst load mem_en",  32'(mem_en),  32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("post-rst load d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("post-rst load d_rdata",     d_rdata,          32'h1122_CDAB);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one synchronous single-port unified memory between the fetch requester (i_*) and the load/store requester (d_*) of the RV32I core.
- Default priority goes to data. A starvation counter forces fetch through after a bounded wait.
- Memory read latency is one cycle. Each requester gets one response pulse per accepted request.
- Sits between the core front end / LSU and the memory macro. It replaces the separate imem/dmem instances when the unified-memory build is used.

Parameters:
- IDX_W, 10, memory word-index width (memory depth = 2^IDX_W words).
- STARVE_LIMIT, 4, consecutive cycles fetch may be refused while i_valid=1 before fetch gets forced priority (range 1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_valid  in  1  fetch request valid
- i_ready  out  1  fetch request accepted this cycle
- i_addr  in  32  fetch byte address
- i_rsp_valid  out  1  fetch response valid, one-cycle pulse
- i_rdata  out  32  fetch read data
- i_rsp_err  out  1  fetch misaligned, qualified by i_rsp_valid
- d_valid  in  1  data request valid
- d_ready  out  1  data request accepted this cycle
- d_addr  in  32  data byte address
- d_we  in  1  1 = store, 0 = load
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_rsp_valid  out  1  data response pulse (loads and stores)
- d_rdata  out  32  load data
- d_rsp_err  out  1  data misaligned, qualified by d_rsp_valid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  IDX_W  memory word index
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_rdata  in  32  memory read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Handshake:
  - A request transfers when valid && ready in the same cycle.
  - Requesters hold valid and the payload stable until ready.
  - At most one grant per cycle. ready is combinational from the valids and the internal state.
- Arbitration:
  - Default: d wins when both are valid.
  - starve_cnt (4 bits) increments each cycle that i_valid=1 and i_ready=0.
  - starve_cnt clears on a fetch grant or when i_valid=0.
  - When starve_cnt >= STARVE_LIMIT, fetch wins the next contested cycle and starve_cnt clears.
- Memory drive:
  - For a granted request, mem_en=1 combinationally in the same cycle.
  - mem_addr = addr[IDX_W+1:2]. mem_we = d_we for data and 0 for fetch.
  - mem_wdata = d_wdata and mem_wstrb = d_wstrb for data. Both are 0 when idle.
- Misalignment:
  - A fetch, or a data access with d_we=0 or d_wstrb=4'hF, is misaligned if addr[1:0]!=0.
  - For sub-word stores, d_wstrb must lie within the addressed word. They are never flagged.
  - A misaligned request is still accepted (ready=1), but mem_en stays 0.
  - Its response carries rsp_err=1 and rdata=0.
- Response pipeline:
  - Registered tag {owner, is_load, err} with a valid bit.
  - Next cycle: the owner's rsp_valid=1. rdata = mem_rdata for a non-error load and 0 otherwise. The other rsp_valid=0.
  - Back-to-back grants give back-to-back responses (throughput 1/cycle).
  - Responses cannot be back-pressured.
- Registered state:
  - Reset values: tag valid=0, starve_cnt=0.
  - Therefore i_rsp_valid=d_rsp_valid=0 and i_rsp_err=d_rsp_err=0 in the cycle after reset.
- Reset mid-operation:
  - With rst_n=0, ready=0 and mem_en=0 combinationally.
  - An in-flight response is discarded.
  - No memory write may occur during any reset cycle.
- Idle: no valids gives mem_en=0, and no response follows.
- Simultaneous events:
  - A grant in cycle N and a response for the cycle N-1 grant coexist.
  - The response for a request accepted in cycle N always appears in cycle N+1.

Test Plan:
- Fetch alone:
  - Stimulus: i_valid=1, i_addr=0x10, with mem[4]=0x00500093.
  - Required: i_ready=1 and mem_en=1, mem_addr=4 in the same cycle.
  - Next cycle: i_rsp_valid=1, i_rdata=0x00500093, i_rsp_err=0.
- Contention:
  - Stimulus: i_valid and d_valid both held with d_addr=0x20 and d_we=0, with mem[8]=0xDEADBEEF.
  - Required: d granted first, then d_rsp_valid=1 with d_rdata=0xDEADBEEF. Fetch waits.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: d_valid held for 10 cycles with i_valid held.
  - Required: fetch granted in the cycle after 4 refusals (cycle 5). Data resumes priority afterwards.
- Store:
  - Stimulus: d_we=1, d_addr=0x40, d_wdata=0x000000AB, d_wstrb=4'b0001.
  - Required: mem_we=1, mem_addr=16, mem_wstrb=0001.
  - Next cycle: d_rsp_valid=1, d_rdata=0. A subsequent load of 0x40 returns byte 0x AB in [7:0], with other bytes unchanged.
- Misaligned:
  - Stimulus: i_addr=0x6.
  - Required: i_ready=1, mem_en=0. Next cycle: i_rsp_valid=1, i_rsp_err=1, i_rdata=0.
- Reset mid-flight:
  - Stimulus: grant a load, then assert rst_n=0 the next cycle.
  - Required: d_rsp_valid=0 during reset, and after release no stale response and mem_en=0 until a new valid arrives.
